mem_access_stage: RTL
=====================

# mem_access_stage

MEM stage of the 5-stage MIPS pipeline: consumes the EX/MEM pipeline register outputs and performs the data-memory access over a variable-latency req/ack bus. It stalls the upstream pipeline while an access is outstanding and drives the MEM/WB register toward write-back.

## Interface

Parameters:
- DATA_W, 32, data and address width
- REG_W, 5, register-index width
- TIMEOUT, 255, max WAIT cycles before bus error (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-low
- regwrite_in  in  1  EX/MEM RegWrite
- memtoreg_in  in  1  EX/MEM MemtoReg (load)
- memwrite_in  in  1  EX/MEM MemWrite (store)
- alu_result_in  in  DATA_W  EX/MEM ALU result / byte address
- write_reg_in  in  REG_W  EX/MEM destination register
- write_data_in  in  DATA_W  EX/MEM store data
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  DATA_W  word-aligned address, registered
- dmem_wdata  out  DATA_W  store data, registered
- dmem_ack  in  1  access complete, 1-cycle pulse
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- mem_hold  out  1  1 = EX/MEM and earlier stages must hold (combinational)
- regwrite_out  out  1  MEM/WB RegWrite
- memtoreg_out  out  1  MEM/WB MemtoReg
- read_data_out  out  DATA_W  MEM/WB load data
- alu_result_out  out  DATA_W  MEM/WB ALU result
- write_reg_out  out  REG_W  MEM/WB destination register
- bus_err  out  1  sticky error flag, cleared only by reset

## Operation

- States: IDLE, WAIT.
- mem op = memtoreg_in | memwrite_in. If both set, treat as store: memtoreg_out forced 0.
- IDLE, no mem op: MEM/WB loads inputs at next edge; read_data_out ← 0; mem_hold = 0.
- IDLE, mem op, alu_result_in[1:0] ≠ 0: no request; bus_err ← 1; MEM/WB loads bubble (regwrite_out = memtoreg_out = 0); mem_hold = 0.
- IDLE, mem op, aligned: mem_hold = 1; at edge, dmem_req ← 1, dmem_we ← memwrite_in, dmem_addr ← alu_result_in, dmem_wdata ← write_data_in; latch regwrite, memtoreg, write_reg and alu_result internally; MEM/WB loads bubble; counter ← 0; → WAIT.
- WAIT, dmem_ack = 0: mem_hold = 1; request signals held stable; MEM/WB holds bubble; counter increments.
- WAIT, dmem_ack = 1: mem_hold = 0; at edge, MEM/WB ← latched fields, read_data_out ← dmem_rdata for load, 0 for store; dmem_req ← 0; → IDLE.
- WAIT, counter = TIMEOUT−1 with no ack: mem_hold = 0; at edge, bus_err ← 1, dmem_req ← 0, MEM/WB loads bubble; → IDLE.
- Ack in IDLE is ignored. Ack on the timeout cycle wins over timeout.
- Reset (any state, including mid-WAIT): state IDLE, dmem_req/dmem_we = 0, dmem_addr/dmem_wdata = 0, all MEM/WB outputs 0, counter 0, bus_err 0.

## Timing

- Non-mem op: 1-cycle latency to MEM/WB, no stall.
- Mem op with ack N cycles after dmem_req rises (N ≥ 0, ack in the same cycle as first req = N 0): mem_hold is high for N+1 cycles. MEM/WB is valid at the edge on which ack is sampled.
- mem_hold falls in the ack cycle, so EX/MEM advances at that same edge. No double issue: the next instruction is seen in IDLE.
- Back-to-back mem ops: dmem_req is low for exactly one cycle between them.

## Structure

- Shared package mips_pkg holds the state enum {IDLE, WAIT}, DATA_W, REG_W, and the MEM/WB bubble constant.
- One sub-module is natural: mem_timeout_ctr, a clearable saturating counter with a terminal-count output, parameterised by TIMEOUT.

## Test plan

- ALU op, regwrite_in=1, alu_result_in=0x0000_1234, write_reg_in=5 -> next edge regwrite_out=1, alu_result_out=0x1234, write_reg_out=5; mem_hold never 1.
- Load from 0x100, ack 3 cycles after req with rdata=0xDEAD_BEEF -> mem_hold high 4 cycles; dmem_addr=0x100, dmem_we=0; read_data_out=0xDEADBEEF and memtoreg_out=1 after ack; exactly one request.
- Store 0xCAFE_F00D to 0x200, ack in the first req cycle -> dmem_we=1, dmem_wdata=0xCAFEF00D, mem_hold 1 cycle, regwrite_out=0; next instruction accepted after.
- Load from 0x102 -> no dmem_req; bus_err=1; bubble on MEM/WB; the following ALU op proceeds normally.
- TIMEOUT=4, no ack -> mem_hold high 4 cycles, then bus_err=1, dmem_req=0, bubble; a later ack is ignored.
- reset low during WAIT -> next edge dmem_req=0, all outputs 0, state IDLE; a fresh load then completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, MEM stage states
// and the MEM/WB bubble control word.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } memwb_ctrl_t;

  // A bubble must never write the register file.
  localparam memwb_ctrl_t MEMWB_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0};

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clearable saturating cycle counter; tc_o flags the last allowed
// WAIT cycle (count == TIMEOUT-1).
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign tc_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory accesses on a req/ack bus, stalls the
// front of the pipe while one is outstanding and feeds MEM/WB.
module mem_access_stage #(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_W   = mips_pkg::REG_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic              memwrite_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic [DATA_W-1:0] write_data_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_hold,
  output logic              regwrite_out,
  output logic              memtoreg_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic              bus_err
);

  import mips_pkg::*;

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  memwb_ctrl_t       lat_ctrl_q, lat_ctrl_d;
  logic [DATA_W-1:0] lat_alu_q, lat_alu_d;
  logic [REG_W-1:0]  lat_reg_q, lat_reg_d;
  memwb_ctrl_t       wb_ctrl_q, wb_ctrl_d;
  logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
  logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
  logic              err_q, err_d;

  logic        mem_op;
  logic        misaligned;
  memwb_ctrl_t in_ctrl;
  logic        ctr_clear;
  logic        ctr_en;
  logic        ctr_tc;

  // A combined load+store is treated as a store, so memtoreg is dropped.
  assign mem_op           = memtoreg_in | memwrite_in;
  assign misaligned       = (alu_result_in[1:0] != 2'b00);
  assign in_ctrl.regwrite = regwrite_in;
  assign in_ctrl.memtoreg = memtoreg_in & ~memwrite_in;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear_i(ctr_clear),
    .en_i   (ctr_en),
    .tc_o   (ctr_tc)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_ctrl_d = lat_ctrl_q;
    lat_alu_d  = lat_alu_q;
    lat_reg_d  = lat_reg_q;
    wb_ctrl_d  = MEMWB_BUBBLE;
    wb_rdata_d = '0;
    wb_alu_d   = '0;
    wb_reg_d   = '0;
    err_d      = err_q;
    mem_hold   = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ctr_clear = 1'b1;
        if (!mem_op) begin
          wb_ctrl_d = in_ctrl;
          wb_alu_d  = alu_result_in;
          wb_reg_d  = write_reg_in;
        end else if (misaligned) begin
          err_d = 1'b1;
        end else begin
          mem_hold   = 1'b1;
          req_d      = 1'b1;
          we_d       = memwrite_in;
          addr_d     = alu_result_in;
          wdata_d    = write_data_in;
          lat_ctrl_d = in_ctrl;
          lat_alu_d  = alu_result_in;
          lat_reg_d  = write_reg_in;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        ctr_en = 1'b1;
        // An ack arriving on the terminal cycle still completes the access.
        if (dmem_ack) begin
          wb_ctrl_d  = lat_ctrl_q;
          wb_rdata_d = lat_ctrl_q.memtoreg ? dmem_rdata : '0;
          wb_alu_d   = lat_alu_q;
          wb_reg_d   = lat_reg_q;
          req_d      = 1'b0;
          state_d    = IDLE;
        end else if (ctr_tc) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          mem_hold = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_ctrl_q <= MEMWB_BUBBLE;
      lat_alu_q  <= '0;
      lat_reg_q  <= '0;
      wb_ctrl_q  <= MEMWB_BUBBLE;
      wb_rdata_q <= '0;
      wb_alu_q   <= '0;
      wb_reg_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_ctrl_q <= lat_ctrl_d;
      lat_alu_q  <= lat_alu_d;
      lat_reg_q  <= lat_reg_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_reg_q   <= wb_reg_d;
      err_q      <= err_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign regwrite_out   = wb_ctrl_q.regwrite;
  assign memtoreg_out   = wb_ctrl_q.memtoreg;
  assign read_data_out  = wb_rdata_q;
  assign alu_result_out = wb_alu_q;
  assign write_reg_out  = wb_reg_q;
  assign bus_err        = err_q;

endmodule
